// File: rtl/prog_loader.sv
// Instruction-memory loader: parses a length-prefixed, XOR-checksummed byte
// stream into 9-bit instruction writes and holds the CPU in reset until verified.
module prog_loader #(
    parameter int ADDR_W    = 12,
    parameter int INST_W    = 9,
    parameter int BASE_ADDR = 0,
    parameter int MAX_COUNT = 2000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [INST_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W-1:0] count
);

    typedef enum logic [2:0] {
        HDR_LO  = 3'd0,
        HDR_HI  = 3'd1,
        INST_LO = 3'd2,
        INST_HI = 3'd3,
        CKSUM   = 3'd4,
        DONE    = 3'd5,
        ERROR   = 3'd6
    } state_t;

    localparam logic [ADDR_W-1:0] LP_MAX  = ADDR_W'(MAX_COUNT);
    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_in_ready;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [INST_W-1:0]   r_wdata;
    logic                r_hold;
    logic                r_done;
    logic                r_err;
    logic [ADDR_W-1:0]   r_count;
    logic [ADDR_W-1:0]   r_len;
    logic [7:0]          r_cksum;
    logic [7:0]          r_lo_byte;

    logic                w_accept;
    logic                w_write;
    logic                w_restart;
    logic [ADDR_W-1:0]   w_len_full;
    logic [ADDR_W-1:0]   w_count_inc;

    function automatic logic f_receiving(input state_t s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == INST_LO) ||
               (s == INST_HI) || (s == CKSUM);
    endfunction

    assign w_accept    = in_valid && r_in_ready;
    assign w_len_full  = ADDR_W'({in_data[3:0], r_len[7:0]});
    assign w_count_inc = r_count + ADDR_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            HDR_LO: begin
                if (w_accept) w_state_nxt = HDR_HI;
            end
            HDR_HI: begin
                if (w_accept) begin
                    if (in_data[7:4] != 4'd0 || w_len_full > LP_MAX)
                        w_state_nxt = ERROR;
                    else if (w_len_full == '0)
                        w_state_nxt = CKSUM;
                    else
                        w_state_nxt = INST_LO;
                end
            end
            INST_LO: begin
                if (w_accept) w_state_nxt = INST_HI;
            end
            INST_HI: begin
                if (w_accept) begin
                    if (in_data[7:1] != 7'd0) begin
                        w_state_nxt = ERROR;
                    end else begin
                        w_write     = 1'b1;
                        w_state_nxt = (w_count_inc == r_len) ? CKSUM : INST_LO;
                    end
                end
            end
            CKSUM: begin
                if (w_accept) w_state_nxt = (in_data == r_cksum) ? DONE : ERROR;
            end
            DONE, ERROR: begin
                if (start) begin
                    w_restart   = 1'b1;
                    w_state_nxt = HDR_LO;
                end
            end
            default: w_state_nxt = HDR_LO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= HDR_LO;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_count    <= '0;
            r_len      <= '0;
            r_cksum    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= f_receiving(w_state_nxt);
            r_we       <= w_write;

            // The checksum byte itself is compared, not folded in.
            if (w_accept && r_state != CKSUM)
                r_cksum <= r_cksum ^ in_data;

            if (w_accept && r_state == HDR_LO)
                r_len <= ADDR_W'(in_data);
            if (w_accept && r_state == HDR_HI)
                r_len <= w_len_full;
            if (w_accept && r_state == INST_LO)
                r_lo_byte <= in_data;

            if (w_write) begin
                r_addr  <= LP_BASE + r_count;
                r_wdata <= INST_W'({in_data[0], r_lo_byte});
                r_count <= w_count_inc;
            end

            if (w_state_nxt == DONE && r_state != DONE) begin
                r_done <= 1'b1;
                r_hold <= 1'b0;
            end
            if (w_state_nxt == ERROR && r_state != ERROR)
                r_err <= 1'b1;

            if (w_restart) begin
                r_count <= '0;
                r_cksum <= '0;
                r_done  <= 1'b0;
                r_err   <= 1'b0;
                r_hold  <= 1'b1;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_hold   = r_hold;
    assign load_done  = r_done;
    assign load_err   = r_err;
    assign count      = r_count;

endmodule
